// File: rtl/keypad_in.sv
// keypad_in: 4x4 matrix keypad scanner with debounce, hex digit entry and a
// read-syscall port that stalls the CPU until an entered value is available.
// Optional feature macro: KEYPAD_TYPEAHEAD_EN turns the single ready slot
// into a 2-entry FIFO so one value can be typed ahead of the CPU.
// Handshake: a read request (i_op == OP_SYSCALL, i_num == 5) is held by the
// CPU; o_valid pulses in the one cycle the value is handed over, o_stall is
// high in every requesting cycle before that, and both are low otherwise.
module keypad_in #(
   parameter int         SCAN_DIV        = 1000,
   parameter int         DEBOUNCE_FRAMES = 4,
   parameter logic [3:0] OP_SYSCALL      = 4'hF
) (
   input  logic        i_clk,
   input  logic        i_rst,
   output logic [3:0]  o_col,
   input  logic [3:0]  i_row,
   input  logic        i_enter,
   input  logic [3:0]  i_op,
   input  logic [31:0] i_num,
   output logic [31:0] o_val,
   output logic        o_valid,
   output logic        o_stall,
   output logic [31:0] o_echo,
   output logic [1:0]  o_state
);

   localparam int DIV_W = $clog2(SCAN_DIV);
   localparam int CNT_W = $clog2(DEBOUNCE_FRAMES + 1);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_DEBOUNCE = 2'd1,
      ST_HELD     = 2'd2
   } state_t;

   logic [3:0]       row_s1, row_s2;
   logic             en_s1, en_s2, en_s3;
   logic [DIV_W-1:0] div_cnt;
   logic [1:0]       col_idx;
   logic             slot_end, frame_done;
   logic             col_hit;
   logic [1:0]       col_row;
   logic [3:0]       cand;
   logic             fr_hit;
   logic [3:0]       fr_dig;
   logic             merged_hit;
   logic [3:0]       merged_dig;
   state_t           state, state_nx;
   logic [3:0]       deb_dig, deb_dig_nx;
   logic [CNT_W-1:0] deb_cnt, deb_cnt_nx;
   logic             accept;
   logic [31:0]      entry;
   logic             enter_rise;
   logic             rd_req;
   logic             ready;
   logic [31:0]      head;
   logic             push, pop;
   logic [31:0]      val_q;

   // Two-flop synchronizers for the asynchronous rows and enter button, plus
   // one extra enter stage for edge detection.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         row_s1 <= 4'hF;
         row_s2 <= 4'hF;
         en_s1  <= 1'b0;
         en_s2  <= 1'b0;
         en_s3  <= 1'b0;
      end else begin
         row_s1 <= i_row;
         row_s2 <= row_s1;
         en_s1  <= i_enter;
         en_s2  <= en_s1;
         en_s3  <= en_s2;
      end
   end

   assign enter_rise = en_s2 & ~en_s3;

   // Column scan timer: each column is driven for SCAN_DIV clocks.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         div_cnt <= '0;
         col_idx <= 2'd0;
      end else if (slot_end) begin
         div_cnt <= '0;
         col_idx <= col_idx + 2'd1;
      end else begin
         div_cnt <= div_cnt + DIV_W'(1);
      end
   end

   assign slot_end   = (div_cnt == DIV_W'(SCAN_DIV - 1));
   assign frame_done = slot_end && (col_idx == 2'd3);
   assign o_col      = ~(4'b0001 << col_idx);

   // Lowest pressed row in the driven column, and the frame-wide lowest digit
   // once this column is folded in.
   always_comb begin
      col_hit = 1'b0;
      col_row = 2'd0;
      for (int r = 3; r >= 0; r--) begin
         if (!row_s2[r]) begin
            col_hit = 1'b1;
            col_row = 2'(r);
         end
      end
      cand       = {col_row, col_idx};
      merged_hit = fr_hit | col_hit;
      merged_dig = fr_dig;
      if (col_hit && (!fr_hit || (cand < fr_dig))) merged_dig = cand;
   end

   // Per-frame accumulator, cleared when the frame result is consumed.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         fr_hit <= 1'b0;
         fr_dig <= 4'd0;
      end else if (frame_done) begin
         fr_hit <= 1'b0;
         fr_dig <= 4'd0;
      end else if (slot_end) begin
         fr_hit <= merged_hit;
         fr_dig <= merged_dig;
      end
   end

   // Debounce FSM state register.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state   <= ST_IDLE;
         deb_dig <= 4'd0;
         deb_cnt <= '0;
      end else begin
         state   <= state_nx;
         deb_dig <= deb_dig_nx;
         deb_cnt <= deb_cnt_nx;
      end
   end

   // Debounce FSM: advances only at frame boundaries; HELD never repeats.
   always_comb begin
      state_nx   = state;
      deb_dig_nx = deb_dig;
      deb_cnt_nx = deb_cnt;
      accept     = 1'b0;
      if (frame_done) begin
         case (state)
            ST_IDLE: begin
               if (merged_hit) begin
                  deb_dig_nx = merged_dig;
                  deb_cnt_nx = CNT_W'(1);
                  if (DEBOUNCE_FRAMES <= 1) begin
                     state_nx = ST_HELD;
                     accept   = 1'b1;
                  end else begin
                     state_nx = ST_DEBOUNCE;
                  end
               end
            end
            ST_DEBOUNCE: begin
               if (!merged_hit) begin
                  state_nx = ST_IDLE;
               end else if (merged_dig != deb_dig) begin
                  deb_dig_nx = merged_dig;
                  deb_cnt_nx = CNT_W'(1);
               end else if (deb_cnt >= CNT_W'(DEBOUNCE_FRAMES - 1)) begin
                  state_nx = ST_HELD;
                  accept   = 1'b1;
               end else begin
                  deb_cnt_nx = deb_cnt + CNT_W'(1);
               end
            end
            ST_HELD: begin
               if (!merged_hit) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
         endcase
      end
   end

   assign o_state = state;

   // Entry register: accepted digits shift in at the bottom, oldest fall off
   // the top. A handed-off entry restarts from zero (or from a digit accepted
   // on that very clock).
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         entry <= 32'd0;
      end else if (push) begin
         entry <= accept ? {28'd0, merged_dig} : 32'd0;
      end else if (accept) begin
         entry <= {entry[27:0], merged_dig};
      end
   end

   assign o_echo = entry;

   assign rd_req  = (i_op == OP_SYSCALL) && (i_num == 32'd5);
   assign pop     = rd_req & ready & ~i_rst;
   assign o_valid = pop;
   assign o_stall = rd_req & ~ready & ~i_rst;
   assign o_val   = pop ? head : val_q;

`ifdef KEYPAD_TYPEAHEAD_EN
   logic [31:0] fifo0, fifo1;
   logic [1:0]  fcnt;

   assign ready = (fcnt != 2'd0);
   assign head  = fifo0;
   assign push  = enter_rise & ((fcnt != 2'd2) | pop);

   // Two-entry typeahead FIFO, fifo0 holds the oldest value.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         fifo0 <= 32'd0;
         fifo1 <= 32'd0;
         fcnt  <= 2'd0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (fcnt == 2'd0) fifo0 <= entry;
               else              fifo1 <= entry;
               fcnt <= fcnt + 2'd1;
            end
            2'b01: begin
               fifo0 <= fifo1;
               fcnt  <= fcnt - 2'd1;
            end
            2'b11: begin
               if (fcnt == 2'd1) begin
                  fifo0 <= entry;
               end else begin
                  fifo0 <= fifo1;
                  fifo1 <= entry;
               end
            end
            default: ;
         endcase
      end
   end
`else
   logic [31:0] slot;
   logic        slot_full;

   assign ready = slot_full;
   assign head  = slot;
   assign push  = enter_rise & (~slot_full | pop);

   // Single ready slot; an enter while full is ignored unless the slot is
   // being read on the same clock.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         slot      <= 32'd0;
         slot_full <= 1'b0;
      end else begin
         if (push) slot <= entry;
         slot_full <= push | (slot_full & ~pop);
      end
   end
`endif

   // Last delivered value, shown on o_val between reads.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         val_q <= 32'd0;
      end else if (pop) begin
         val_q <= head;
      end
   end

endmodule

// File: tb/tb_keypad_in.sv
// tb_keypad_in: directed and randomized checks of keypad_in against a
// behavioural model (typed-digit accumulator plus a queue of entered values).
module tb_keypad_in;

   localparam int         SCAN_DIV = 4;
   localparam int         DEB      = 2;
   localparam int         FRAME    = 4 * SCAN_DIV;
   localparam logic [3:0] OP_SYS   = 4'hF;
`ifdef KEYPAD_TYPEAHEAD_EN
   localparam int CAP = 2;
`else
   localparam int CAP = 1;
`endif
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_DEB  = 2'd1;

   logic        i_clk, i_rst;
   logic [3:0]  o_col, i_row, i_op;
   logic        i_enter;
   logic [31:0] i_num, o_val, o_echo;
   logic        o_valid, o_stall;
   logic [1:0]  o_state;

   int          n_cmp = 0;
   int          n_fail = 0;
   logic [31:0] exp_q[$];
   logic [31:0] model_entry;
   logic        key_down;
   logic [3:0]  key_dig;
   bit          rd_window;

   keypad_in #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_FRAMES(DEB), .OP_SYSCALL(OP_SYS)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .o_col(o_col), .i_row(i_row),
      .i_enter(i_enter), .i_op(i_op), .i_num(i_num), .o_val(o_val),
      .o_valid(o_valid), .o_stall(o_stall), .o_echo(o_echo), .o_state(o_state)
   );

   // clock
   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // keypad matrix: the pressed key pulls its row low while its column is driven
   always_comb begin
      i_row = 4'hF;
      if (key_down && !o_col[key_dig[1:0]]) i_row[key_dig[3:2]] = 1'b0;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
      end
   endtask

   // o_valid must only ever appear while the bench is issuing a read
   always @(negedge i_clk) begin
      if (o_valid === 1'b1) chk("valid_outside_read", 32'(rd_window), 32'd1);
   end

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic check_reset_outputs();
      chk("rst_col", 32'(o_col), 32'hE);
      chk("rst_val", o_val, 32'd0);
      chk("rst_valid", 32'(o_valid), 32'd0);
      chk("rst_stall", 32'(o_stall), 32'd0);
      chk("rst_echo", o_echo, 32'd0);
      chk("rst_state", 32'(o_state), 32'(ST_IDLE));
   endtask

   task automatic do_reset();
      i_rst = 1'b1;
      @(negedge i_clk);
      check_reset_outputs();
      key_down = 1'b0;
      i_enter = 1'b0;
      i_op = 4'd0;
      i_num = 32'd0;
      rd_window = 1'b0;
      exp_q.delete();
      model_entry = 32'd0;
      tick();
      tick();
      i_rst = 1'b0;
   endtask

   // hold a key for three frames, release for three: exactly one digit
   task automatic press(input logic [3:0] d);
      key_dig = d;
      key_down = 1'b1;
      repeat (3 * FRAME) tick();
      key_down = 1'b0;
      repeat (3 * FRAME) tick();
      model_entry = {model_entry[27:0], d};
   endtask

   task automatic enter_key();
      i_enter = 1'b1;
      if (exp_q.size() < CAP) begin
         exp_q.push_back(model_entry);
         model_entry = 32'd0;
      end
      repeat (8) tick();
      i_enter = 1'b0;
      repeat (8) tick();
   endtask

   task automatic rd(input bit want, input int budget, input bit hold_extra, output int stalls);
      bit got;
      logic [31:0] exp_v;
      got = 1'b0;
      stalls = 0;
      exp_v = 32'd0;
      rd_window = 1'b1;
      i_op = OP_SYS;
      i_num = 32'd5;
      for (int k = 0; k < budget; k++) begin
         @(negedge i_clk);
         if (o_valid === 1'b1) begin
            got = 1'b1;
            break;
         end
         chk("stall_wait", 32'(o_stall), 32'd1);
         stalls++;
         tick();
      end
      chk("read_done", 32'(got), 32'(want));
      if (got) begin
         chk("read_stall_low", 32'(o_stall), 32'd0);
         chk("read_avail", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) exp_v = exp_q.pop_front();
         chk("read_val", o_val, exp_v);
         if (hold_extra) begin
            tick();
            @(negedge i_clk);
            chk("valid_one_cycle", 32'(o_valid), 32'd0);
            chk("stall_after_pop", 32'(o_stall), 32'd1);
         end
      end
      tick();
      i_op = 4'd0;
      i_num = 32'd0;
      rd_window = 1'b0;
      if (got) begin
         @(negedge i_clk);
         chk("val_held", o_val, exp_v);
         tick();
      end
   endtask

   initial begin
      int stalls;
      bit found, seen;
      logic [3:0] prev_col, exp_col;
      logic [31:0] e0;

      i_enter = 1'b0;
      key_down = 1'b0;
      key_dig = 4'd0;
      rd_window = 1'b0;
      model_entry = 32'd0;
      // read request held during reset: stall must stay low
      i_op = OP_SYS;
      i_num = 32'd5;
      do_reset();

      // column rotation after reset release
      for (int k = 0; k < 8 * SCAN_DIV; k++) begin
         @(negedge i_clk);
         exp_col = ~(4'b0001 << ((k / SCAN_DIV) % 4));
         chk("col_scan", 32'(o_col), 32'(exp_col));
      end
      tick();

      // single presses accumulate hex digits
      press(4'h6);
      chk("echo_6", o_echo, model_entry);
      press(4'h0);
      chk("echo_60", o_echo, model_entry);
      press(4'h0);
      chk("echo_600", o_echo, model_entry);

      // one-frame glitch on column 3, row 3
      e0 = model_entry;
      found = 1'b0;
      prev_col = o_col;
      for (int k = 0; k < 3 * FRAME; k++) begin
         tick();
         if (o_col === 4'b0111 && prev_col !== 4'b0111) begin
            found = 1'b1;
            break;
         end
         prev_col = o_col;
      end
      chk("glitch_align", 32'(found), 32'd1);
      key_dig = 4'hF;
      key_down = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < FRAME; k++) begin
         tick();
         if (o_state === ST_DEB) seen = 1'b1;
         if (k == 5) key_down = 1'b0;
      end
      chk("glitch_debounce_seen", 32'(seen), 32'd1);
      repeat (2 * FRAME) tick();
      chk("glitch_state", 32'(o_state), 32'(ST_IDLE));
      chk("glitch_echo", o_echo, e0);

      // type 1,2,3, enter, read
      do_reset();
      press(4'h1);
      press(4'h2);
      press(4'h3);
      enter_key();
      chk("enter_clears_echo", o_echo, 32'd0);
      rd(1'b1, 20, 1'b1, stalls);
      chk("no_stall_when_ready", 32'(stalls), 32'd0);
      chk("echo_after_read", o_echo, 32'd0);

      // read waits, then 7 is typed and entered
      do_reset();
      fork
         rd(1'b1, 600, 1'b0, stalls);
         begin
            repeat (50) tick();
            press(4'h7);
            enter_key();
         end
      join
      chk("stall_length", 32'(stalls >= 50), 32'd1);

      // two entries before any read
      do_reset();
      press(4'hA);
      enter_key();
      press(4'hB);
      enter_key();
      rd(1'b1, 20, 1'b0, stalls);
      rd(exp_q.size() != 0, 60, 1'b0, stalls);
      chk("echo_after_two", o_echo, model_entry);

      // enter edge and consuming read on the same clock
      do_reset();
      press(4'h4);
      enter_key();
      press(4'h5);
      i_enter = 1'b1;
      tick();
      tick();
      // enter is now through both synchronizer stages; its edge acts next clock
      rd_window = 1'b1;
      i_op = OP_SYS;
      i_num = 32'd5;
      @(negedge i_clk);
      chk("same_clk_valid", 32'(o_valid), 32'd1);
      chk("same_clk_old_val", o_val, exp_q.pop_front());
      exp_q.push_back(model_entry);
      model_entry = 32'd0;
      tick();
      i_op = 4'd0;
      i_num = 32'd0;
      rd_window = 1'b0;
      repeat (8) tick();
      i_enter = 1'b0;
      repeat (8) tick();
      chk("same_clk_echo", o_echo, 32'd0);
      rd(1'b1, 20, 1'b0, stalls);

      // reset during debounce drops the digit
      do_reset();
      key_dig = 4'h9;
      key_down = 1'b1;
      found = 1'b0;
      for (int k = 0; k < 3 * FRAME; k++) begin
         tick();
         if (o_state === ST_DEB) begin
            found = 1'b1;
            break;
         end
      end
      chk("reached_debounce", 32'(found), 32'd1);
      do_reset();
      repeat (4 * FRAME) tick();
      chk("deb_reset_echo", o_echo, 32'd0);
      chk("deb_reset_state", 32'(o_state), 32'(ST_IDLE));

      // reset during a stalled read
      rd_window = 1'b1;
      i_op = OP_SYS;
      i_num = 32'd5;
      repeat (10) begin
         @(negedge i_clk);
         chk("pre_reset_stall", 32'(o_stall), 32'd1);
         tick();
      end
      do_reset();
      repeat (2 * FRAME) tick();
      chk("stall_reset_val", o_val, 32'd0);
      chk("stall_reset_stall", 32'(o_stall), 32'd0);

      // nine digits: the first falls off the top
      do_reset();
      for (int d = 1; d <= 9; d++) press(4'(d));
      chk("echo_overflow", o_echo, model_entry);

      // randomized typing, entering and reading
      do_reset();
      for (int it = 0; it < 5; it++) begin
         int nd;
         nd = $urandom_range(1, 3);
         for (int j = 0; j < nd; j++) press(4'($urandom_range(0, 15)));
         chk("rand_echo_typed", o_echo, model_entry);
         enter_key();
         chk("rand_echo_enter", o_echo, model_entry);
         if ($urandom_range(0, 1) == 1) rd(1'b1, 10, 1'b0, stalls);
      end
      for (int k = 0; k < 4 && exp_q.size() != 0; k++) rd(1'b1, 10, 1'b0, stalls);
      rd(1'b0, 20, 1'b0, stalls);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/keypad_in.md
KEYPAD_IN -- requirements
Module: keypad_in

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000, clocks each column is driven before its rows are sampled (min 2).
REQ-002 SHALL have parameter DEBOUNCE_FRAMES, default 4, consecutive identical full scan frames needed to accept a key (min 1).
REQ-003 SHALL have port i_clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port i_rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port o_col  output  4  column drive, active-low, exactly one bit low outside reset.
REQ-006 SHALL have port i_row  input  4  row sense, active-low, asynchronous to i_clk.
REQ-007 SHALL have port i_enter  input  1  enter button, active-high, asynchronous.
REQ-008 SHALL have port i_op  input  4  decoded CPU opcode.
REQ-009 SHALL have port i_num  input  32  syscall number.
REQ-010 SHALL have port o_val  output  32  value returned to the CPU.
REQ-011 SHALL have port o_valid  output  1  one-cycle pulse, o_val is valid.
REQ-012 SHALL have port o_stall  output  1  CPU hold request while a read syscall waits.
REQ-013 SHALL have port o_echo  output  32  digits being typed, for the 7-segment display syscall.

Function
REQ-014 SHALL pass i_row and i_enter through two-flop synchronizers before use.
REQ-015 SHALL cycle the low bit of o_col 0->1->2->3->0, advancing every SCAN_DIV clocks, and sample the synchronized rows on the last clock of each column slot.
REQ-016 SHALL map column c, row r to hex digit 4*r+c; with several keys down in one frame, the lowest digit wins.
REQ-017 SHALL run FSM IDLE -> DEBOUNCE (key seen in a frame) -> HELD (same digit seen DEBOUNCE_FRAMES frames in a row) -> IDLE (a complete frame with no key).
REQ-018 SHALL return DEBOUNCE -> IDLE on an empty frame and restart the DEBOUNCE count on a different digit.
REQ-019 SHALL, on entering HELD, shift the digit into the entry register: entry <= {entry[27:0], digit}; o_echo = entry; digits above 8 are discarded silently.
REQ-020 SHALL accept one digit per press; auto-repeat is forbidden while in HELD.
REQ-021 SHALL detect the rising edge of synchronized i_enter; on that edge, move entry to the ready slot, set ready, and clear entry to 0.
REQ-022 SHALL treat an enter while ready is already set (slot full) as ignored: entry is kept, nothing is lost.
REQ-023 SHALL treat a read request as i_op == OP_SYSCALL and i_num == 32'd5, sampled each clock.
REQ-024 SHALL, on a read request with ready set, drive o_val = slot and pulse o_valid for that same cycle, clear ready on the next edge, and keep o_stall low.
REQ-025 SHALL, on a read request with ready clear, hold o_stall high, combinationally, until ready is set; o_valid then pulses in the first cycle ready is seen.
REQ-026 SHALL, when an enter edge and the consuming read fall on the same clock, deliver the old slot value and load the new one; ready stays set.
REQ-027 SHALL hold o_val at the last delivered value between reads.

Reset
REQ-028 SHALL, while i_rst is high, force o_col = 4'b1110, o_val = 0, o_valid = 0, o_stall = 0, o_echo = 0, FSM = IDLE, and clear ready, scan counters and synchronizers.
REQ-029 SHALL let reset asserted mid-debounce or mid-stall drop the pending digit and the pending read with no o_valid pulse.

Configuration
REQ-030 SHALL implement a typeahead buffer controlled by macro KEYPAD_TYPEAHEAD_EN; when defined, the ready slot becomes a 2-entry FIFO (enter ignored only when both are full; reads pop oldest first); when undefined, the single slot of REQ-021/022 applies.

Verification (SCAN_DIV=4, DEBOUNCE_FRAMES=2)
REQ-031 SHALL cover: press col 2, row 1 for 3 frames, release, repeat for col 0, row 0 -> o_echo = 32'h60 then 32'h600.
REQ-032 SHALL cover: 1-frame glitch on row 3, col 3 -> o_echo unchanged, FSM back to IDLE.
REQ-033 SHALL cover: type 1,2,3 then enter, then read syscall -> o_val = 32'h123, o_valid one cycle, o_stall never high, o_echo = 0.
REQ-034 SHALL cover: read syscall with nothing ready, then type 7 and enter 50 cycles later -> o_stall high throughout, o_valid with o_val = 32'h7 when ready sets.
REQ-035 SHALL cover: two entries 32'hA and 32'hB entered before any read -> without macro, reads return A then stall (B still in o_echo); with KEYPAD_TYPEAHEAD_EN, reads return A then B.
REQ-036 SHALL cover: i_rst pulsed during DEBOUNCE and during a stalled read -> all outputs at reset values, no o_valid.
